// File: rtl/n8_pkg.sv
// Shared N8 controller-link definitions: button bit positions, frame size and
// the responder state encoding used by the driver, the responder and the key decoder.
`timescale 1ns/1ps
package n8_pkg;

  localparam int N8_NUM_BUTTONS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [1:0] {
    N8R_IDLE,
    N8R_LOAD,
    N8R_SHIFT,
    N8R_DONE
  } n8r_state_e;

endpackage

// File: rtl/n8_sync_edge.sv
// Multi-flop synchronizer for an asynchronous strobe pin, followed by a
// one-flop edge detector producing the synchronized level plus rise/fall flags.
`timescale 1ns/1ps
module n8_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  // SYNC_STAGES must be at least 2 for metastability settling.
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      prev_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pin};
      prev_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  // ---- edge-detect stage ----
  assign level = sync_p0[SYNC_STAGES-1];
  assign rise  = sync_p0[SYNC_STAGES-1] & ~prev_p1;
  assign fall  = ~sync_p0[SYNC_STAGES-1] & prev_p1;

endmodule

// File: rtl/n8_responder.sv
// Pad-side end of the N8 serial link: emulates the controller's parallel-in /
// serial-out register, answering host latch/pulse strobes on an active-low data line.
`timescale 1ns/1ps
module n8_responder
  import n8_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int N_BUTTONS    = N8_NUM_BUTTONS,
  parameter int IDLE_TIMEOUT = 50_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 latch_in,
  input  logic                 pulse_in,
  input  logic [N_BUTTONS-1:0] buttons,
  output logic                 data_out,
  output logic [3:0]           bit_index,
  output logic                 frame_done,
  output logic                 frame_abort,
  output logic                 idle_timeout
);

  localparam int               CNT_W    = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [3:0]       IDX_LAST = 4'(N_BUTTONS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(IDLE_TIMEOUT);

  function automatic logic [3:0] sat_idx(input logic [3:0] idx);
    return (idx >= IDX_LAST) ? IDX_LAST : idx + 4'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
  endfunction

  logic latch_s, latch_rise, latch_fall, pulse_rise;
  logic pulse_unused_level, pulse_unused_fall;

  n8_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (latch_in),
    .level (latch_s),
    .rise  (latch_rise),
    .fall  (latch_fall)
  );

  n8_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (pulse_in),
    .level (pulse_unused_level),
    .rise  (pulse_rise),
    .fall  (pulse_unused_fall)
  );

  logic pulse_unused;
  assign pulse_unused = pulse_unused_level ^ pulse_unused_fall;

  n8r_state_e             state, state_n;
  logic [N_BUTTONS-1:0]   shreg, shreg_n, shifted;
  logic [3:0]             idx_n;
  logic                   data_n, done_n, abort_n, idle_n;
  logic [CNT_W-1:0]       idle_cnt, idle_cnt_n;

  // ---- next-state stage: decisions from synchronized strobe events ----
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    idx_n      = bit_index;
    data_n     = data_out;
    done_n     = 1'b0;
    abort_n    = 1'b0;
    shifted    = {1'b0, shreg[N_BUTTONS-1:1]};

    case (state)
      N8R_IDLE: begin
        data_n = 1'b1;
        if (latch_rise) state_n = N8R_LOAD;
      end
      N8R_LOAD: begin
        if (latch_fall) state_n = N8R_SHIFT;
      end
      N8R_SHIFT: begin
        // A new latch takes priority over a coincident pulse.
        if (latch_rise) begin
          abort_n = (bit_index < IDX_LAST);
          state_n = N8R_LOAD;
        end else if (pulse_rise) begin
          shreg_n = shifted;
          idx_n   = sat_idx(bit_index);
          data_n  = ~shifted[0];
          if (idx_n == IDX_LAST) begin
            done_n  = 1'b1;
            state_n = N8R_DONE;
          end
        end
      end
      N8R_DONE: begin
        data_n = 1'b1;
        idx_n  = IDX_LAST;
        if (latch_rise) state_n = N8R_LOAD;
      end
      default: state_n = N8R_IDLE;
    endcase

    // Transparent parallel load on every latch-high cycle, including the entry cycle.
    if (state_n == N8R_LOAD && latch_s) begin
      shreg_n = buttons;
      idx_n   = 4'd0;
      data_n  = ~buttons[BTN_A];
    end

    idle_cnt_n = latch_rise ? '0 : sat_cnt(idle_cnt);
    idle_n     = (idle_cnt_n == CNT_MAX);
  end

  // ---- register stage: all outputs registered ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= N8R_IDLE;
      shreg        <= '0;
      data_out     <= 1'b1;
      bit_index    <= IDX_LAST;
      frame_done   <= 1'b0;
      frame_abort  <= 1'b0;
      idle_timeout <= 1'b0;
      idle_cnt     <= '0;
    end else begin
      state        <= state_n;
      shreg        <= shreg_n;
      data_out     <= data_n;
      bit_index    <= idx_n;
      frame_done   <= done_n;
      frame_abort  <= abort_n;
      idle_timeout <= idle_n;
      idle_cnt     <= idle_cnt_n;
    end
  end

endmodule

// File: doc/n8_responder.md
Name: n8_responder

Overview:
- Device-side end of the N8 (NES-style) controller serial link: emulates the pad's parallel-in/serial-out register.
- Drives the data line in response to latch/pulse strobes issued by the existing N8 polling driver.
- Button state comes from board switches/keys or test logic.
- Used for on-board loopback (driver ↔ responder on GPIO) and as a synthesizable bench model for the driver.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on latch_in and pulse_in (min 2).
- N_BUTTONS, 8, bits per frame.
- IDLE_TIMEOUT, 50_000_000, clk cycles without latch activity before idle_timeout asserts (1 s at 50 MHz).

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- latch_in  in  1  latch strobe from host, asynchronous to clk
- pulse_in  in  1  clock strobe from host, asynchronous to clk
- buttons  in  N_BUTTONS  pressed=1; bit order A,B,Select,Start,Up,Down,Left,Right (bit0=A)
- data_out  out  1  serial data to host, active-low (pressed=0)
- bit_index  out  4  index of bit currently presented (0..N_BUTTONS; N_BUTTONS = exhausted)
- frame_done  out  1  one-cycle pulse when the last button bit is shifted out
- frame_abort  out  1  one-cycle pulse when latch rises while in SHIFT with bit_index < N_BUTTONS
- idle_timeout  out  1  level; high while no latch rise seen for IDLE_TIMEOUT cycles

Behaviour:
- Reset values: state IDLE, shreg=0, data_out=1, bit_index=N_BUTTONS, frame_done=0, frame_abort=0, idle_timeout=0, idle counter=0.
- latch_in and pulse_in each pass through SYNC_STAGES flops, then a 1-flop edge detector giving latch_s, latch_rise, latch_fall, pulse_rise.
- All outputs are registered.
- Pin-to-output latency is SYNC_STAGES+1 clk cycles from the first clk edge sampling the new pin level.
- States:
  - IDLE: data_out=1. latch_rise → LOAD.
  - LOAD: while latch_s=1, shreg<=buttons every cycle (transparent parallel load); bit_index=0; data_out=~buttons[0] (registered). pulse_rise in LOAD is ignored. latch_fall → SHIFT; shreg holds the value loaded on the last latch-high cycle.
  - SHIFT:
    - On pulse_rise: shreg<={1'b0, shreg[N-1:1]}; bit_index<=bit_index+1, saturating at N_BUTTONS; data_out<=~shreg_next[0].
    - On the shift that makes bit_index=N_BUTTONS: frame_done=1 for one cycle, next state DONE.
    - latch_rise with bit_index<N_BUTTONS → frame_abort=1 for one cycle, then LOAD.
  - DONE: data_out=1 (zeros shifted in read as released). Further pulse_rise has no effect; bit_index stays N_BUTTONS. latch_rise → LOAD.
- Simultaneous latch_rise and pulse_rise in the same cycle: latch wins and the shift is discarded.
- Simultaneous latch_fall and pulse_rise: enter SHIFT and discard that pulse.
- buttons is sampled only in LOAD. Changes during SHIFT/DONE do not affect the current frame.
- Idle counter: cleared on latch_rise, otherwise increments, saturating at IDLE_TIMEOUT. idle_timeout=1 when counter==IDLE_TIMEOUT, cleared the cycle after the next latch_rise.
- Reset mid-frame returns to IDLE immediately (asynchronous); data_out=1 until the next latch.

Decomposition:
- Package n8_pkg:
  - button index constants BTN_A=0 … BTN_RIGHT=7
  - N8_NUM_BUTTONS=8
  - typedef enum logic [1:0] {N8R_IDLE, N8R_LOAD, N8R_SHIFT, N8R_DONE}
  - to be shared with the existing driver and key decoder.
- Sub-module n8_sync_edge: parameterized SYNC_STAGES synchronizer plus edge detector (outputs level, rise, fall). Instantiated twice (latch, pulse).

Test Plan:
- Reset asserted, then released with no strobes → data_out=1, bit_index=8, idle_timeout rises after exactly IDLE_TIMEOUT cycles (use IDLE_TIMEOUT=100 in bench).
- buttons=8'b1001_0101, latch 12 µs pulse then 8 pulses (6 µs half-period) → data_out serial stream 0,1,0,1,0,1,1,0 (active-low, A first); frame_done high exactly one cycle after the 8th pulse_rise.
- After a full frame, 4 extra pulses → data_out stays 1, bit_index stays 8, no further frame_done.
- buttons=8'hFF, latch, 3 pulses, latch again with buttons=8'h00 → frame_abort one cycle; new frame reads eight 1s.
- Latch and pulse rising in the same clk (bench drives both pins together) → treated as latch only: bit_index=0, no shift.
- buttons changed from 8'h01 to 8'h02 during SHIFT after bit 0 → current frame still reads A pressed (0) then seven 1s; next frame reads 1,0,1,1,1,1,1,1.
